// File: rtl/spi_reg_burst.sv
// SPI register-access slave: 16-bit header, DATA_W-bit burst words, all four SPI modes.
module spi_reg_burst #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SPI_MODE = 0,
  parameter int unsigned STATUS_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spi_clk,
  input  logic                spi_cs_n,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic                reg_wr,
  output logic                reg_rd,
  input  logic [DATA_W-1:0]   reg_rdata,
  input  logic [STATUS_W-1:0] status,
  output logic                busy,
  output logic                frame_err
);

  localparam int unsigned HDR_W = 16;
  localparam int unsigned SR_W  = (DATA_W > HDR_W) ? DATA_W : HDR_W;
  localparam int unsigned CNT_W = $clog2(SR_W + 1);
  localparam bit          CPOL  = ((SPI_MODE / 2) % 2) == 1;
  localparam bit          CPHA  = (SPI_MODE % 2) == 1;

  typedef enum logic [1:0] {WAIT_HIGH, IDLE, HEADER, DATA} state_t;

  state_t             state;
  state_t             state_d;
  logic [1:0]         sck_sync;
  logic [1:0]         cs_sync;
  logic [1:0]         mosi_sync;
  logic [1:0]         sync_ok;
  logic               sck_q;
  logic               cs_q;
  logic [SR_W-1:0]    rx_sr;
  logic [SR_W-1:0]    rx_next;
  logic [SR_W-1:0]    tx_sr;
  logic [CNT_W-1:0]   bit_cnt;
  logic               rw_q;
  logic               inc_q;
  logic               rd_pend;

  logic sck_rise_c, sck_fall_c, lead_c, trail_c;
  logic sample_c, change_c, cs_fall_c, cs_rise_c;
  logic in_frame_c, start_c, hdr_done_c, word_done_c, end_c, err_c;

  // Two-flop synchronisers plus edge-detect history; sync_ok marks when cs_sync holds a real pin sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sync_ok   <= 2'b00;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], spi_clk};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sync_ok   <= {sync_ok[0], 1'b1};
      sck_q     <= sck_sync[1];
      cs_q      <= cs_sync[1];
    end
  end

  assign sck_rise_c = sck_sync[1] & ~sck_q;
  assign sck_fall_c = ~sck_sync[1] & sck_q;
  assign lead_c     = CPOL ? sck_fall_c : sck_rise_c;
  assign trail_c    = CPOL ? sck_rise_c : sck_fall_c;
  // Gate with the previous cs level so an edge coinciding with cs rise is still taken.
  assign sample_c   = ~cs_q & (CPHA ? trail_c : lead_c);
  assign change_c   = ~cs_q & (CPHA ? lead_c : trail_c);
  assign cs_fall_c  = cs_q & ~cs_sync[1];
  assign cs_rise_c  = ~cs_q & cs_sync[1];
  assign rx_next    = {rx_sr[SR_W-2:0], mosi_sync[1]};
  assign spi_miso   = tx_sr[SR_W-1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_HIGH;
    else     state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    unique case (state)
      WAIT_HIGH: if (sync_ok[1] && cs_sync[1]) state_d = IDLE;
      IDLE:      if (cs_fall_c) state_d = HEADER;
      HEADER:    if (cs_rise_c) state_d = IDLE;
                 else if (hdr_done_c) state_d = DATA;
      DATA:      if (cs_rise_c) state_d = IDLE;
      default:   state_d = WAIT_HIGH;
    endcase
  end

  // Frame event decode; a sample edge in the cs-rise cycle is counted before the abort check.
  always_comb begin
    in_frame_c  = (state == HEADER) || (state == DATA);
    start_c     = (state == IDLE) && cs_fall_c;
    hdr_done_c  = (state == HEADER) && sample_c && (bit_cnt == CNT_W'(HDR_W - 1));
    word_done_c = (state == DATA) && sample_c && (bit_cnt == CNT_W'(DATA_W - 1));
    end_c       = in_frame_c && cs_rise_c;
    err_c       = end_c && !(hdr_done_c || word_done_c) && (sample_c || (bit_cnt != '0));
  end

  // Frame datapath: shift registers, bit counter, register strobes and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sr     <= '0;
      tx_sr     <= '0;
      bit_cnt   <= '0;
      rw_q      <= 1'b0;
      inc_q     <= 1'b0;
      rd_pend   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
      rd_pend   <= reg_rd;
      if (reg_wr && inc_q) reg_addr <= reg_addr + ADDR_W'(1);
      if (start_c) begin
        tx_sr   <= SR_W'(status) << (SR_W - STATUS_W);
        bit_cnt <= '0;
        busy    <= 1'b1;
      end
      if (rd_pend && (state == DATA) && !rw_q)
        tx_sr <= SR_W'(reg_rdata) << (SR_W - DATA_W);
      // The first change edge of every word keeps the freshly loaded MSB on the line.
      if (change_c && in_frame_c && (bit_cnt != '0))
        tx_sr <= {tx_sr[SR_W-2:0], 1'b0};
      if (sample_c && in_frame_c) begin
        rx_sr   <= rx_next;
        bit_cnt <= (hdr_done_c || word_done_c) ? '0 : bit_cnt + CNT_W'(1);
      end
      if (hdr_done_c) begin
        rw_q     <= rx_next[HDR_W-1];
        inc_q    <= rx_next[HDR_W-2];
        reg_addr <= rx_next[ADDR_W-1:0];
        reg_rd   <= ~rx_next[HDR_W-1];
        if (rx_next[HDR_W-1]) tx_sr <= '0;
      end
      if (word_done_c) begin
        if (rw_q) begin
          reg_wdata <= rx_next[DATA_W-1:0];
          reg_wr    <= 1'b1;
        end else begin
          reg_rd <= 1'b1;
          if (inc_q) reg_addr <= reg_addr + ADDR_W'(1);
        end
      end
      if (end_c) begin
        busy      <= 1'b0;
        frame_err <= err_c;
        bit_cnt   <= '0;
        tx_sr     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_burst.sv
// Bench for spi_reg_burst: one instance per SPI mode, randomized frames against a transaction-level model.
module tb_spi_reg_burst;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STATUS_W = 8;
  localparam int          HALF     = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                sck   [4];
  logic                csn   [4];
  logic                mosi;
  logic                miso  [4];
  logic [ADDR_W-1:0]   addr  [4];
  logic [DATA_W-1:0]   wdata [4];
  logic [DATA_W-1:0]   rdata [4];
  logic                wr    [4];
  logic                rd    [4];
  logic                busy  [4];
  logic                ferr  [4];
  logic [STATUS_W-1:0] st    [4];

  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_reg_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SPI_MODE(m), .STATUS_W(STATUS_W)) u_dut (
      .clk(clk), .rst(rst), .spi_clk(sck[m]), .spi_cs_n(csn[m]), .spi_mosi(mosi),
      .spi_miso(miso[m]), .reg_addr(addr[m]), .reg_wdata(wdata[m]), .reg_wr(wr[m]),
      .reg_rd(rd[m]), .reg_rdata(rdata[m]), .status(st[m]), .busy(busy[m]), .frame_err(ferr[m]));
  end

  function automatic logic [31:0] reg_val(input logic [5:0] a);
    return 32'(a) * 32'h11111111;
  endfunction

  // Register file: data for the address read is valid the cycle after reg_rd.
  always @(posedge clk) begin
    for (int m = 0; m < 4; m++) if (rd[m] === 1'b1) rdata[m] <= reg_val(addr[m]);
  end

  int total = 0;
  int bad   = 0;
  logic [37:0] wr_q[$];
  logic [5:0]  rd_q[$];
  logic        miso_q[$];
  logic [37:0] exp_wr[$];
  logic [5:0]  exp_rd[$];
  logic        exp_miso[$];
  logic [31:0] words[8];
  int ferr_n, both_n;
  logic busy_mid, busy_end;

  // Strobe monitor.
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (wr[m] === 1'b1) wr_q.push_back({addr[m], wdata[m]});
      if (rd[m] === 1'b1) rd_q.push_back(addr[m]);
      if (ferr[m] === 1'b1) ferr_n++;
      if (wr[m] === 1'b1 && rd[m] === 1'b1) both_n++;
    end
  end

  // Expected transactions and MISO stream for one complete frame of n words.
  function automatic void build_expect(input logic [7:0] s, input logic [15:0] hdr, input int n);
    logic [5:0]  a, ak;
    logic [31:0] v;
    exp_wr.delete(); exp_rd.delete(); exp_miso.delete();
    a = hdr[5:0];
    for (int i = 0; i < 16; i++) exp_miso.push_back(i < 8 ? s[7-i] : 1'b0);
    if (!hdr[15]) exp_rd.push_back(a);
    for (int k = 0; k < n; k++) begin
      ak = a + (hdr[14] ? 6'(k) : 6'd0);
      v  = hdr[15] ? 32'd0 : reg_val(ak);
      for (int j = 31; j >= 0; j--) exp_miso.push_back(v[j]);
      if (hdr[15]) exp_wr.push_back({ak, words[k]});
      else exp_rd.push_back(a + (hdr[14] ? 6'(k + 1) : 6'd0));
    end
  endfunction

  function automatic int wr_diff();
    if (wr_q.size() != exp_wr.size()) return (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
    foreach (wr_q[i]) if (wr_q[i] !== exp_wr[i]) return i;
    return -1;
  endfunction

  function automatic int rd_diff();
    if (rd_q.size() != exp_rd.size()) return (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
    foreach (rd_q[i]) if (rd_q[i] !== exp_rd[i]) return i;
    return -1;
  endfunction

  function automatic int miso_diff();
    if (miso_q.size() != exp_miso.size()) return (miso_q.size() < exp_miso.size()) ? miso_q.size() : exp_miso.size();
    foreach (miso_q[i]) if (miso_q[i] !== exp_miso[i]) return i;
    return -1;
  endfunction

  // SPI master: shifts header + words[0..n-1], stops after nbits, optionally ends the frame.
  task automatic spi_xfer(input int m, input logic [15:0] hdr, input int n, input int nbits, input bit raise);
    logic bits[$];
    bit cpol, cpha;
    cpol = ((m / 2) % 2) == 1;
    cpha = (m % 2) == 1;
    for (int i = 15; i >= 0; i--) bits.push_back(hdr[i]);
    for (int k = 0; k < n; k++) for (int j = 31; j >= 0; j--) bits.push_back(words[k][j]);
    miso_q.delete(); wr_q.delete(); rd_q.delete();
    ferr_n = 0; both_n = 0; busy_mid = 1'b0; busy_end = 1'b1;
    sck[m] = cpol;
    repeat (HALF) @(negedge clk);
    csn[m] = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == 8) busy_mid = busy[m];
      if (!cpha) begin
        mosi = bits[i];
        repeat (HALF) @(negedge clk);
        miso_q.push_back(miso[m]);
        sck[m] = ~cpol;
        repeat (HALF) @(negedge clk);
        sck[m] = cpol;
      end else begin
        sck[m] = ~cpol;
        mosi = bits[i];
        repeat (HALF) @(negedge clk);
        miso_q.push_back(miso[m]);
        sck[m] = cpol;
        repeat (HALF) @(negedge clk);
      end
    end
    if (raise) begin
      repeat (HALF) @(negedge clk);
      csn[m] = 1'b1;
      repeat (4 * HALF) @(negedge clk);
      busy_end = busy[m];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      total++;
      if ({miso[m], addr[m], wdata[m], wr[m], rd[m], busy[m], ferr[m]} !== '0) begin
        bad++;
        $display("FAIL reset_outputs m=%0d got busy=%b addr=%h wdata=%h miso=%b need all 0",
                 m, busy[m], addr[m], wdata[m], miso[m]);
      end
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      total++;
      if ({busy[m], wr[m], rd[m], ferr[m]} !== 4'b0) begin
        bad++;
        $display("FAIL idle_after_reset m=%0d got busy=%b wr=%b rd=%b ferr=%b need 0", m, busy[m], wr[m], rd[m], ferr[m]);
      end
    end
  endtask

  task automatic test_single_write();
    st[0] = 8'($urandom);
    words[0] = 32'hDEADBEEF;
    build_expect(st[0], 16'h8005, 1);
    spi_xfer(0, 16'h8005, 1, 48, 1'b1);
    total++;
    if (wr_diff() !== -1) begin bad++; $display("FAIL single_write_wr diff_at=%0d got_n=%0d need_n=%0d", wr_diff(), wr_q.size(), exp_wr.size()); end
    total++;
    if (wr_q.size() == 1 && wr_q[0] !== {6'd5, 32'hDEADBEEF}) begin bad++; $display("FAIL single_write_value got %h need %h", wr_q[0], {6'd5, 32'hDEADBEEF}); end
    total++;
    if (rd_q.size() !== 0) begin bad++; $display("FAIL single_write_rd got %0d reads need 0", rd_q.size()); end
    total++;
    if (miso_diff() !== -1) begin bad++; $display("FAIL single_write_miso diff_at=%0d", miso_diff()); end
    total++;
    if ({ferr_n, busy_mid, busy_end} !== {32'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL single_write_flags got ferr=%0d busy_mid=%b busy_end=%b need 0 1 0", ferr_n, busy_mid, busy_end);
    end
  endtask

  task automatic test_burst_write_wrap();
    logic [15:0] hdr;
    hdr = 16'hC03F;
    st[3] = 8'($urandom);
    for (int k = 0; k < 3; k++) words[k] = $urandom;
    build_expect(st[3], hdr, 3);
    spi_xfer(3, hdr, 3, 112, 1'b1);
    total++;
    if (wr_diff() !== -1) begin bad++; $display("FAIL wrap_write_wr diff_at=%0d got_n=%0d need_n=%0d", wr_diff(), wr_q.size(), exp_wr.size()); end
    total++;
    if (wr_q.size() == 3 && wr_q[1][37:32] !== 6'd0) begin bad++; $display("FAIL wrap_write_addr got %h need 00", wr_q[1][37:32]); end
    total++;
    if (miso_diff() !== -1) begin bad++; $display("FAIL wrap_write_miso diff_at=%0d", miso_diff()); end
    total++;
    if ({ferr_n, both_n} !== 64'd0) begin bad++; $display("FAIL wrap_write_err got ferr=%0d overlap=%0d need 0 0", ferr_n, both_n); end
  endtask

  task automatic test_burst_read();
    logic [15:0] hdr;
    hdr = 16'h4002;
    st[1] = 8'($urandom);
    build_expect(st[1], hdr, 2);
    spi_xfer(1, hdr, 2, 80, 1'b1);
    total++;
    if (rd_diff() !== -1) begin bad++; $display("FAIL burst_read_rd diff_at=%0d got_n=%0d need_n=%0d", rd_diff(), rd_q.size(), exp_rd.size()); end
    total++;
    if (miso_diff() !== -1) begin bad++; $display("FAIL burst_read_miso diff_at=%0d", miso_diff()); end
    total++;
    if (wr_q.size() !== 0) begin bad++; $display("FAIL burst_read_wr got %0d writes need 0", wr_q.size()); end
    total++;
    if ({ferr_n, busy_mid, busy_end} !== {32'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL burst_read_flags got ferr=%0d busy_mid=%b busy_end=%b need 0 1 0", ferr_n, busy_mid, busy_end);
    end
  endtask

  task automatic test_read_noinc();
    logic [15:0] hdr;
    hdr = {2'b00, 8'($urandom), 6'($urandom)};
    st[2] = 8'($urandom);
    build_expect(st[2], hdr, 2);
    spi_xfer(2, hdr, 2, 80, 1'b1);
    total++;
    if (rd_diff() !== -1) begin bad++; $display("FAIL noinc_read_rd diff_at=%0d got_n=%0d need_n=%0d", rd_diff(), rd_q.size(), exp_rd.size()); end
    total++;
    if (miso_diff() !== -1) begin bad++; $display("FAIL noinc_read_miso diff_at=%0d", miso_diff()); end
    total++;
    if (addr[2] !== hdr[5:0]) begin bad++; $display("FAIL noinc_read_addr got %h need %h", addr[2], hdr[5:0]); end
  endtask

  task automatic test_abort();
    logic [15:0] hdr;
    hdr = {2'b10, 8'h00, 6'($urandom)};
    words[0] = $urandom;
    spi_xfer(0, hdr, 1, 20, 1'b1);
    total++;
    if ({wr_q.size(), rd_q.size()} !== 64'd0) begin bad++; $display("FAIL abort_strobes got wr=%0d rd=%0d need 0 0", wr_q.size(), rd_q.size()); end
    total++;
    if (ferr_n !== 1) begin bad++; $display("FAIL abort_frame_err got %0d pulse cycles need 1", ferr_n); end
    total++;
    if (busy_end !== 1'b0) begin bad++; $display("FAIL abort_busy got %b need 0", busy_end); end
    st[0] = 8'($urandom);
    words[0] = $urandom;
    words[1] = $urandom;
    hdr = {2'b11, 8'h00, 6'($urandom)};
    build_expect(st[0], hdr, 2);
    spi_xfer(0, hdr, 2, 80, 1'b1);
    total++;
    if (wr_diff() !== -1) begin bad++; $display("FAIL after_abort_wr diff_at=%0d got_n=%0d need_n=%0d", wr_diff(), wr_q.size(), exp_wr.size()); end
    total++;
    if (ferr_n !== 0) begin bad++; $display("FAIL after_abort_err got %0d need 0", ferr_n); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] hdr;
    hdr = {2'b11, 8'h00, 6'($urandom)};
    for (int k = 0; k < 2; k++) words[k] = $urandom;
    spi_xfer(0, hdr, 2, 56, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({miso[0], addr[0], wdata[0], wr[0], rd[0], busy[0], ferr[0]} !== '0) begin
      bad++; $display("FAIL reset_mid_outputs got busy=%b addr=%h wdata=%h need all 0", busy[0], addr[0], wdata[0]);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    wr_q.delete(); rd_q.delete(); ferr_n = 0;
    for (int i = 0; i < 20; i++) begin
      mosi = 1'($urandom);
      repeat (HALF) @(negedge clk);
      sck[0] = 1'b1;
      repeat (HALF) @(negedge clk);
      sck[0] = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    total++;
    if ({busy[0], 32'(wr_q.size()), 32'(rd_q.size()), 32'(ferr_n)} !== '0) begin
      bad++; $display("FAIL reset_mid_no_start got busy=%b wr=%0d rd=%0d ferr=%0d need 0", busy[0], wr_q.size(), rd_q.size(), ferr_n);
    end
    csn[0] = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    st[0] = 8'($urandom);
    hdr = {2'b10, 8'h00, 6'($urandom)};
    words[0] = $urandom;
    build_expect(st[0], hdr, 1);
    spi_xfer(0, hdr, 1, 48, 1'b1);
    total++;
    if (wr_diff() !== -1) begin bad++; $display("FAIL reset_mid_restart_wr diff_at=%0d got_n=%0d need_n=%0d", wr_diff(), wr_q.size(), exp_wr.size()); end
    total++;
    if (miso_diff() !== -1) begin bad++; $display("FAIL reset_mid_restart_miso diff_at=%0d", miso_diff()); end
  endtask

  task automatic test_random();
    int m, n;
    logic [15:0] hdr;
    for (int f = 0; f < 10; f++) begin
      m = $urandom_range(0, 3);
      n = $urandom_range(0, 3);
      hdr = {1'($urandom), 1'($urandom), 8'($urandom), 6'($urandom)};
      st[m] = 8'($urandom);
      for (int k = 0; k < n; k++) words[k] = $urandom;
      build_expect(st[m], hdr, n);
      spi_xfer(m, hdr, n, 16 + 32 * n, 1'b1);
      total++;
      if (wr_diff() !== -1) begin bad++; $display("FAIL rand_wr f=%0d m=%0d diff_at=%0d got_n=%0d need_n=%0d", f, m, wr_diff(), wr_q.size(), exp_wr.size()); end
      total++;
      if (rd_diff() !== -1) begin bad++; $display("FAIL rand_rd f=%0d m=%0d diff_at=%0d got_n=%0d need_n=%0d", f, m, rd_diff(), rd_q.size(), exp_rd.size()); end
      total++;
      if (miso_diff() !== -1) begin bad++; $display("FAIL rand_miso f=%0d m=%0d hdr=%h diff_at=%0d", f, m, hdr, miso_diff()); end
      total++;
      if ({ferr_n, both_n, busy_mid, busy_end} !== {64'd0, 1'b1, 1'b0}) begin
        bad++; $display("FAIL rand_flags f=%0d m=%0d got ferr=%0d overlap=%0d busy_mid=%b busy_end=%b need 0 0 1 0",
                        f, m, ferr_n, both_n, busy_mid, busy_end);
      end
    end
  endtask

  initial begin
    mosi = 1'b0;
    for (int m = 0; m < 4; m++) begin
      sck[m] = ((m / 2) % 2) == 1;
      csn[m] = 1'b1;
      st[m]  = '0;
    end
    test_reset();
    test_single_write();
    test_burst_write_wrap();
    test_burst_read();
    test_read_noinc();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
